// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Column/row counters with active / front porch / sync / back porch decode,
// programmable sync polarity, a pixel clock-enable and line/frame strobes.
// Every output is registered from the same pre-increment count, so all
// outputs describe the same raster position one cycle after it was counted.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CNT_W    = 10
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  output logic             H_Sync,
  output logic             V_Sync,
  output logic             Active,
  output logic             Line_Start,
  output logic             Frame_Start,
  output logic [CNT_W-1:0] CountCol,
  output logic [CNT_W-1:0] CountRow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Segment boundaries, fixed at elaboration; the only runtime adders are the
  // counter increments.
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic H_ASSERT = (H_POL != 0);
  localparam logic V_ASSERT = (V_POL != 0);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Reject segment widths of zero and totals that do not fit the counters.
  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_seg
      $error("vga_timing_gen: every segment width must be at least 1");
    end
    if (CNT_W < 1 || CNT_W > 30 ||
        ((H_TOTAL - 1) >> CNT_W) != 0 ||
        ((V_TOTAL - 1) >> CNT_W) != 0) begin : g_bad_width
      $error("vga_timing_gen: CNT_W too narrow for H_TOTAL-1 / V_TOTAL-1");
    end
  endgenerate

  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] count_col_q, count_col_d;
  logic [CNT_W-1:0] count_row_q, count_row_d;
  logic             h_sync_q, h_sync_d;
  logic             v_sync_q, v_sync_d;
  logic             active_q, active_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  // Next-state: decode the current count into outputs and advance the raster,
  // only on enabled cycles; strobes fall to 0 whenever EN is low.
  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    count_col_d   = count_col_q;
    count_row_d   = count_row_q;
    h_sync_d      = h_sync_q;
    v_sync_d      = v_sync_q;
    active_d      = active_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (EN) begin
      count_col_d   = col_q;
      count_row_d   = row_q;
      h_sync_d      = ((col_q >= H_SYNC_BEG) && (col_q < H_SYNC_END)) ? H_ASSERT : ~H_ASSERT;
      v_sync_d      = ((row_q >= V_SYNC_BEG) && (row_q < V_SYNC_END)) ? V_ASSERT : ~V_ASSERT;
      active_d      = (col_q < H_ACT_END) && (row_q < V_ACT_END);
      line_start_d  = (col_q == '0);
      frame_start_d = (col_q == '0) && (row_q == '0);
      if (col_q == H_LAST) begin
        col_d = '0;
        row_d = (row_q == V_LAST) ? '0 : row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  // State and output registers, cleared asynchronously to the idle raster.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      col_q         <= '0;
      row_q         <= '0;
      count_col_q   <= '0;
      count_row_q   <= '0;
      h_sync_q      <= ~H_ASSERT;
      v_sync_q      <= ~V_ASSERT;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      count_col_q   <= count_col_d;
      count_row_q   <= count_row_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign H_Sync      = h_sync_q;
  assign V_Sync      = v_sync_q;
  assign Active      = active_q;
  assign Line_Start  = line_start_q;
  assign Frame_Start = frame_start_q;
  assign CountCol    = count_col_q;
  assign CountRow    = count_row_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480, a tiny 8x6
// raster, and default timing with active-high syncs) share clock, reset and
// enable. A behavioural raster model predicts every cycle's outputs into
// per-instance queues at the clock edge; a monitor pops and compares them.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic       ls;
    logic       fs;
    logic [9:0] col;
    logic [9:0] row;
  } out_t;

  logic clk;
  logic rst_n;
  logic en;

  int n_checks;
  int n_errors;

  // Per-instance timing, indexed 0 = default, 1 = small, 2 = polarity.
  int p_ha [3] = '{640, 4, 640};
  int p_hfp[3] = '{16, 1, 16};
  int p_hs [3] = '{96, 2, 96};
  int p_hbp[3] = '{48, 1, 48};
  int p_va [3] = '{480, 3, 480};
  int p_vfp[3] = '{10, 1, 10};
  int p_vs [3] = '{2, 1, 2};
  int p_vbp[3] = '{33, 1, 33};
  bit p_hp [3] = '{1'b0, 1'b0, 1'b1};
  bit p_vp [3] = '{1'b0, 1'b0, 1'b1};

  logic       hs [3];
  logic       vs [3];
  logic       act[3];
  logic       ls [3];
  logic       fs [3];
  logic [9:0] col[3];
  logic [9:0] row[3];

  vga_timing_gen dut_def (
    .CLK(clk), .RST_N(rst_n), .EN(en),
    .H_Sync(hs[0]), .V_Sync(vs[0]), .Active(act[0]),
    .Line_Start(ls[0]), .Frame_Start(fs[0]),
    .CountCol(col[0]), .CountRow(row[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_small (
    .CLK(clk), .RST_N(rst_n), .EN(en),
    .H_Sync(hs[1]), .V_Sync(vs[1]), .Active(act[1]),
    .Line_Start(ls[1]), .Frame_Start(fs[1]),
    .CountCol(col[1]), .CountRow(row[1])
  );

  vga_timing_gen #(.H_POL(1), .V_POL(1)) dut_pol (
    .CLK(clk), .RST_N(rst_n), .EN(en),
    .H_Sync(hs[2]), .V_Sync(vs[2]), .Active(act[2]),
    .Line_Start(ls[2]), .Frame_Start(fs[2]),
    .CountCol(col[2]), .CountRow(row[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs for raster position (c, r) of instance k.
  function automatic out_t decode(input int k, input int c, input int r);
    out_t o;
    int hb, vb;
    hb = p_ha[k] + p_hfp[k];
    vb = p_va[k] + p_vfp[k];
    o.col = 10'(c);
    o.row = 10'(r);
    o.hs  = (c >= hb && c < hb + p_hs[k]) ? p_hp[k] : ~p_hp[k];
    o.vs  = (r >= vb && r < vb + p_vs[k]) ? p_vp[k] : ~p_vp[k];
    o.act = (c < p_ha[k]) && (r < p_va[k]);
    o.ls  = (c == 0);
    o.fs  = (c == 0) && (r == 0);
    return o;
  endfunction

  function automatic out_t reset_vals(input int k);
    out_t o;
    o     = '0;
    o.hs  = ~p_hp[k];
    o.vs  = ~p_vp[k];
    return o;
  endfunction

  int   m_col [3];
  int   m_row [3];
  out_t m_last[3];
  out_t q0[$];
  out_t q1[$];
  out_t q2[$];

  // Model: predict what each instance presents after this edge.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      out_t e;
      int ht, vt;
      ht = p_ha[k] + p_hfp[k] + p_hs[k] + p_hbp[k];
      vt = p_va[k] + p_vfp[k] + p_vs[k] + p_vbp[k];
      if (!rst_n) begin
        m_col[k] = 0;
        m_row[k] = 0;
        e = reset_vals(k);
      end else if (en) begin
        e = decode(k, m_col[k], m_row[k]);
        if (m_col[k] == ht - 1) begin
          m_col[k] = 0;
          m_row[k] = (m_row[k] == vt - 1) ? 0 : m_row[k] + 1;
        end else begin
          m_col[k] = m_col[k] + 1;
        end
      end else begin
        e    = m_last[k];
        e.ls = 1'b0;
        e.fs = 1'b0;
      end
      m_last[k] = e;
      case (k)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  end

  // Monitor: pop each instance's prediction and compare every output.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      out_t e;
      int sz;
      sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
      if (sz == 0) begin
        check_val($sformatf("d%0d.sb_empty", k), 32'd0, 32'd1);
      end else begin
        case (k)
          0:       e = q0.pop_front();
          1:       e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        check_val($sformatf("d%0d.col", k), 32'(col[k]), 32'(e.col));
        check_val($sformatf("d%0d.row", k), 32'(row[k]), 32'(e.row));
        check_val($sformatf("d%0d.hsync", k), 32'(hs[k]), 32'(e.hs));
        check_val($sformatf("d%0d.vsync", k), 32'(vs[k]), 32'(e.vs));
        check_val($sformatf("d%0d.active", k), 32'(act[k]), 32'(e.act));
        check_val($sformatf("d%0d.line_start", k), 32'(ls[k]), 32'(e.ls));
        check_val($sformatf("d%0d.frame_start", k), 32'(fs[k]), 32'(e.fs));
      end
    end
  end

  task automatic check_reset_now(input string phase);
    for (int k = 0; k < 3; k++) begin
      out_t r;
      r = reset_vals(k);
      check_val($sformatf("%s.d%0d.col", phase, k), 32'(col[k]), 32'd0);
      check_val($sformatf("%s.d%0d.row", phase, k), 32'(row[k]), 32'd0);
      check_val($sformatf("%s.d%0d.hsync", phase, k), 32'(hs[k]), 32'(r.hs));
      check_val($sformatf("%s.d%0d.vsync", phase, k), 32'(vs[k]), 32'(r.vs));
      check_val($sformatf("%s.d%0d.active", phase, k), 32'(act[k]), 32'd0);
      check_val($sformatf("%s.d%0d.line_start", phase, k), 32'(ls[k]), 32'd0);
      check_val($sformatf("%s.d%0d.frame_start", phase, k), 32'(fs[k]), 32'd0);
    end
  endtask

  initial begin
    int hs_low_cnt, hs_low_first, hs_low_last, pol_hs_high, def_ls_cnt;
    int sm_act_cnt, sm_fs_cnt, sm_fs_first, sm_fs_second;
    int budget, ls_cnt;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    en    = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check_reset_now("reset");
    $display("phase reset: checks=%0d errors=%0d", n_checks, n_errors);

    // Free run: two default lines, many small frames.
    hs_low_cnt = 0; hs_low_first = -1; hs_low_last = -1; pol_hs_high = 0;
    def_ls_cnt = 0; sm_act_cnt = 0; sm_fs_cnt = 0; sm_fs_first = -1; sm_fs_second = -1;
    rst_n = 1'b1;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      #1;
      if (i < 800) begin
        if (hs[0] == 1'b0) begin
          hs_low_cnt++;
          if (hs_low_first < 0) hs_low_first = int'(col[0]);
          hs_low_last = int'(col[0]);
        end
        if (hs[2] == 1'b1) pol_hs_high++;
        if (ls[0]) def_ls_cnt++;
      end
      if (i < 96) begin
        if (act[1]) sm_act_cnt++;
        if (fs[1]) begin
          sm_fs_cnt++;
          if (sm_fs_first < 0) sm_fs_first = i;
          else if (sm_fs_second < 0) sm_fs_second = i;
        end
      end
    end
    check_val("def.hsync_low_cycles", 32'(hs_low_cnt), 32'd96);
    check_val("def.hsync_low_first_col", 32'(hs_low_first), 32'd656);
    check_val("def.hsync_low_last_col", 32'(hs_low_last), 32'd751);
    check_val("pol.hsync_high_cycles", 32'(pol_hs_high), 32'd96);
    check_val("def.line_starts_per_line", 32'(def_ls_cnt), 32'd1);
    check_val("small.active_cycles_2frames", 32'(sm_act_cnt), 32'd24);
    check_val("small.frame_starts_2frames", 32'(sm_fs_cnt), 32'd2);
    check_val("small.frame_period", 32'(sm_fs_second - sm_fs_first), 32'd48);
    $display("phase free_run: checks=%0d errors=%0d", n_checks, n_errors);

    // EN gating 1,0,0,1 starting at column 0 of the default raster.
    budget = 0;
    while (col[0] != 10'd799 && budget < 1000) begin
      @(negedge clk);
      #1;
      budget++;
    end
    check_val("gate.reach_col799", 32'(budget < 1000), 32'd1);
    ls_cnt = 0;
    @(negedge clk); #1;
    if (ls[0]) ls_cnt++;
    check_val("gate.col0", 32'(col[0]), 32'd0);
    en = 1'b0;
    @(negedge clk); #1;
    if (ls[0]) ls_cnt++;
    check_val("gate.hold1_col", 32'(col[0]), 32'd0);
    @(negedge clk); #1;
    if (ls[0]) ls_cnt++;
    check_val("gate.hold2_active", 32'(act[0]), 32'd1);
    en = 1'b1;
    @(negedge clk); #1;
    if (ls[0]) ls_cnt++;
    check_val("gate.resume_col", 32'(col[0]), 32'd1);
    check_val("gate.line_start_count", 32'(ls_cnt), 32'd1);
    $display("phase en_gating: checks=%0d errors=%0d", n_checks, n_errors);

    // Asynchronous reset mid-line, between clock edges.
    budget = 0;
    while (col[0] != 10'd300 && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    check_val("mid.reach_col300", 32'(budget < 1000), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_now("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_val("mid.release_col", 32'(col[0]), 32'd0);
    check_val("mid.release_row", 32'(row[0]), 32'd0);
    check_val("mid.release_frame_start", 32'(fs[0]), 32'd1);
    check_val("mid.release_active", 32'(act[0]), 32'd1);
    $display("phase mid_reset: checks=%0d errors=%0d", n_checks, n_errors);

    // Frame wrap on the small raster: col 7 / row 5 then the next edge.
    budget = 0;
    while (!(col[1] == 10'd7 && row[1] == 10'd5) && budget < 100) begin
      @(negedge clk);
      #1;
      budget++;
    end
    check_val("wrap.reach_last", 32'(budget < 100), 32'd1);
    check_val("wrap.last_vsync", 32'(vs[1]), 32'd1);
    @(negedge clk); #1;
    check_val("wrap.col", 32'(col[1]), 32'd0);
    check_val("wrap.row", 32'(row[1]), 32'd0);
    check_val("wrap.frame_start", 32'(fs[1]), 32'd1);
    check_val("wrap.vsync", 32'(vs[1]), 32'd1);
    $display("phase wrap: checks=%0d errors=%0d", n_checks, n_errors);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator: column/row counters with full front-porch / sync / back-porch decode.
- Provides programmable sync polarity, a pixel clock-enable, an active-video flag, and line/frame start strobes.
- Sits between the pixel clock domain and the pixel source (pattern generator, frame buffer reader); drives the VGA connector syncs directly.
- Successor to the fixed 640x480 active/sync-only counter.

Parameters:
- H_ACTIVE, 640, visible columns per line
- H_FP, 16, horizontal front porch (columns)
- H_SYNC, 96, horizontal sync width (columns)
- H_BP, 48, horizontal back porch (columns)
- V_ACTIVE, 480, visible rows per frame
- V_FP, 10, vertical front porch (rows)
- V_SYNC, 2, vertical sync width (rows)
- V_BP, 33, vertical back porch (rows)
- H_POL, 0, asserted level of H_Sync (0 = active-low)
- V_POL, 0, asserted level of V_Sync (0 = active-low)
- CNT_W, 10, counter width; must hold max(H_TOTAL-1, V_TOTAL-1)

Ports:
- CLK  input  1  pixel clock
- RST_N  input  1  asynchronous active-low reset
- EN  input  1  pixel clock-enable; counters advance only when high
- H_Sync  output  1  horizontal sync, polarity per H_POL
- V_Sync  output  1  vertical sync, polarity per V_POL
- Active  output  1  high when the reported position is inside H_ACTIVE x V_ACTIVE
- Line_Start  output  1  one-cycle strobe when the reported column is 0
- Frame_Start  output  1  one-cycle strobe when the reported column is 0 and row is 0
- CountCol  output  CNT_W  reported column, 0..H_TOTAL-1
- CountRow  output  CNT_W  reported row, 0..V_TOTAL-1

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
  - Segment order within a line and within a frame: active, front porch, sync, back porch.
- Reset (RST_N low, asynchronous):
  - Internal column and row counters = 0.
  - CountCol = 0, CountRow = 0.
  - H_Sync = ~H_POL, V_Sync = ~V_POL.
  - Active = 0, Line_Start = 0, Frame_Start = 0.
- Counters:
  - On each CLK edge with EN=1, the column counter increments.
  - At H_TOTAL-1 the column counter wraps to 0 and the row counter increments.
  - At row V_TOTAL-1 with column H_TOTAL-1, both counters wrap to 0.
  - No counter ever exceeds its TOTAL-1.
- Output registration:
  - All outputs are registered and decoded from the same pre-increment counter value, so they are mutually aligned.
  - Latency: internal count to outputs is 1 cycle.
  - The first EN=1 edge after reset release presents col 0 / row 0: Active=1, Line_Start=1, Frame_Start=1.
- Decode (on the reported position c, r):
  - H_Sync = H_POL when H_ACTIVE+H_FP <= c < H_ACTIVE+H_FP+H_SYNC, else ~H_POL.
  - V_Sync = V_POL when V_ACTIVE+V_FP <= r < V_ACTIVE+V_FP+V_SYNC, else ~V_POL. V_Sync is row-based and changes together with the column wrap.
  - Active = (c < H_ACTIVE) && (r < V_ACTIVE).
  - Line_Start = (c == 0); Frame_Start = (c == 0 && r == 0).
- EN low:
  - Counters, CountCol, CountRow, H_Sync, V_Sync and Active hold their values.
  - Line_Start and Frame_Start are forced to 0, so each strobe lasts exactly one CLK cycle per position.
- Mid-operation reset: everything returns to the reset values immediately; the next frame starts cleanly from 0/0 after release.
- Arithmetic:
  - All comparisons are unsigned at CNT_W bits.
  - Segment boundaries are computed from the parameters at elaboration time; there are no runtime adders beyond the counter increments.
- Parameter constraints: all segment widths >= 1, and V_TOTAL-1 and H_TOTAL-1 must fit in CNT_W. Violations are flagged by an elaboration-time check.

Test Plan:
- Defaults, EN=1, 2 frames:
  - H_Sync low exactly for CountCol 656..751.
  - V_Sync low exactly for CountRow 490..491.
  - Active high for 307200 cycles per frame.
  - Frame_Start period = 420000 cycles.
- Small params (H 4/1/2/1, V 3/1/1/1; H_TOTAL=8, V_TOTAL=6):
  - CountCol sequence 0..7 wraps; row wraps after 48 cycles.
  - H_Sync low at col 5..6; V_Sync low at row 4.
- Polarity (H_POL=1, V_POL=1, defaults otherwise):
  - Reset gives H_Sync=0, V_Sync=0.
  - H_Sync high only at cols 656..751.
- EN gating (EN toggling 1,0,0,1 starting at col 0):
  - Outputs hold across the EN=0 cycles.
  - Line_Start is high exactly once.
  - The count resumes at col 1.
- Reset mid-frame (assert RST_N=0 at col 300 / row 200 asynchronously between edges):
  - Outputs go to reset values before the next edge.
  - After release, the first EN edge gives Frame_Start=1 with CountCol=0, CountRow=0.
- Wrap boundary (col 799 / row 524, then the next edge):
  - CountCol=0, CountRow=0, Frame_Start=1, V_Sync deasserted.
